// File: rtl/pulse_gen_adc_pkg.sv
// Shared definitions for the synthetic ADC pulse source: sample width, FSM state type, LFSR seed.
package pulse_gen_adc_pkg;

    localparam int SIZE_ADC_DATA = 14;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        DECAY,
        HOLD
    } pulse_state_t;

    localparam logic [15:0] PULSE_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/pulse_gen_adc_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that dithers the synthetic ADC samples.
// Used only when PULSE_GEN_NOISE_EN is defined.
module lfsr16
    import pulse_gen_adc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= PULSE_LFSR_SEED;
        end else begin
            out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
        end
    end

endmodule

// File: rtl/pulse_gen_adc.sv
// Synthetic ADC source: on trigger emits baseline + linear rise + exponential decay, then a hold-off.
// Optional PULSE_GEN_NOISE_EN adds signed 4-bit LFSR noise to every sample.
//
// state | meaning
// IDLE  | armed, v = 0, waiting for trig
// RISE  | v ramps by a >> RISE_SHIFT per cycle, last cycle forces v = a
// DECAY | v -= v >> DECAY_SHIFT until that step is zero
// HOLD  | v = 0, hold-off down-counter; done on the last cycle
module pulse_gen_adc #(
    parameter int SIZE_ADC_DATA = pulse_gen_adc_pkg::SIZE_ADC_DATA,
    parameter int BASELINE      = 100,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int HOLDOFF       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     done,
    output logic                     trig_lost
);
    import pulse_gen_adc_pkg::*;

    localparam int VW = SIZE_ADC_DATA + 1;
    localparam int SW = SIZE_ADC_DATA + 3;
    localparam logic signed [SW-1:0]  SAT_MAX   = {3'b000, {SIZE_ADC_DATA{1'b1}}};
    localparam logic signed [SW-1:0]  BASE_S    = SW'(BASELINE);
    localparam logic [SIZE_ADC_DATA-1:0] BASE_OUT = SIZE_ADC_DATA'(BASELINE);
    localparam logic [15:0] RISE_LAST = 16'((1 << RISE_SHIFT) - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF);

    pulse_state_t             state;
    logic [VW-1:0]            v;
    logic [VW-1:0]            v_nxt;
    logic [SIZE_ADC_DATA-1:0] a;
    logic [15:0]              cnt;
    logic signed [SW-1:0]     noise_s;
    logic signed [SW-1:0]     sum;
    logic [SIZE_ADC_DATA-1:0] out_nxt;

`ifdef PULSE_GEN_NOISE_EN
    logic [15:0] lfsr_out;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr_out)
    );

    assign noise_s = {{(SW-4){lfsr_out[3]}}, lfsr_out[3:0]};
`else
    assign noise_s = '0;
`endif

    always_comb begin
        v_nxt = '0;
        case (state)
            IDLE:  v_nxt = '0;
            RISE:  v_nxt = (cnt == RISE_LAST) ? {1'b0, a} : v + VW'(a >> RISE_SHIFT);
            DECAY: v_nxt = ((v >> DECAY_SHIFT) == '0) ? '0 : v - (v >> DECAY_SHIFT);
            HOLD:  v_nxt = '0;
            default: v_nxt = '0;
        endcase
    end

    // Output is registered from v_nxt so the sample lines up with the v it represents.
    always_comb begin
        sum = $signed({2'b00, v_nxt}) + BASE_S + noise_s;
        if (sum < 0) begin
            out_nxt = '0;
        end else if (sum > SAT_MAX) begin
            out_nxt = SAT_MAX[SIZE_ADC_DATA-1:0];
        end else begin
            out_nxt = sum[SIZE_ADC_DATA-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            v           <= '0;
            a           <= '0;
            cnt         <= '0;
            output_data <= BASE_OUT;
            busy        <= 1'b0;
            done        <= 1'b0;
            trig_lost   <= 1'b0;
        end else begin
            v           <= v_nxt;
            output_data <= out_nxt;
            done        <= 1'b0;
            if (trig && busy) begin
                trig_lost <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig) begin
                        a     <= amplitude;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RISE;
                    end
                end
                RISE: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == RISE_LAST) begin
                        state <= DECAY;
                    end
                end
                DECAY: begin
                    if ((v >> DECAY_SHIFT) == '0) begin
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                        done  <= (HOLDOFF == 1);
                    end
                end
                HOLD: begin
                    // done is registered, so it is raised one edge ahead of the last count.
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd2) begin
                        done <= 1'b1;
                    end
                    if (cnt == 16'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
